// File: rtl/lzd_seq_pkg.sv
// Shared types and elaboration-time sizing helpers for the sequential leading-zero scanner.
package lzd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } lzd_state_e;

  function automatic int calc_w(input int m, input int extra_bits, input int sign_bit);
    return m + extra_bits - sign_bit;
  endfunction

  function automatic int calc_nchunk(input int w, input int chunk);
    return (w + chunk - 1) / chunk;
  endfunction

  function automatic int calc_pw(input int w, input int chunk);
    return calc_nchunk(w, chunk) * chunk;
  endfunction

  function automatic int calc_shift_width(input int w);
    return $clog2(w - 1);
  endfunction

  function automatic int calc_idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  // All-zero difference is reported as a lone MSB above the normal shift range.
  function automatic int zero_shift_code(input int shift_width);
    return 1 << shift_width;
  endfunction

endpackage

// File: rtl/lzd_chunk_enc.sv
// Combinational priority encoder: leading-zero count of one CHUNK-bit slice, MSB first.
module lzd_chunk_enc #(
  parameter  int CHUNK = 4,
  localparam int LZW   = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] chunk_i,
  output logic             nonzero_o,
  output logic [LZW-1:0]   lz_o
);

  always_comb begin
    nonzero_o = |chunk_i;
    lz_o      = LZW'(CHUNK);
    // Ascending scan: the highest set bit is the last to write lz_o.
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (chunk_i[i]) begin
        lz_o = LZW'(CHUNK - 1 - i);
      end
    end
  end

endmodule

// File: rtl/lzd_scan_sequencer.sv
// Multi-cycle leading-zero controller: |A-B| scanned MSB-first, CHUNK bits per cycle.
// Define LZD_SEQ_NORM_EN to add the norm_mant output and its shifter.
module lzd_scan_sequencer
  import lzd_seq_pkg::*;
#(
  parameter  int M           = 23,
  parameter  int EXTRA_BITS  = 7,
  parameter  int SIGN_BIT    = 1,
  parameter  int CHUNK       = 4,
  localparam int W           = calc_w(M, EXTRA_BITS, SIGN_BIT),
  localparam int SHIFT_WIDTH = calc_shift_width(W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SHIFT_WIDTH:0] shift_amt,
  output logic                 b_gt_a
`ifdef LZD_SEQ_NORM_EN
  ,
  output logic [W-1:0]         norm_mant
`endif
);

  localparam int NCHUNK = calc_nchunk(W, CHUNK);
  localparam int PW     = calc_pw(W, CHUNK);
  localparam int PAD    = PW - W;
  localparam int CIDX_W = calc_idx_width(NCHUNK);
  localparam int LZW    = $clog2(CHUNK) + 1;
  localparam int SW1    = SHIFT_WIDTH + 1;

  localparam logic [SW1-1:0]    ZERO_SHIFT = SW1'(zero_shift_code(SHIFT_WIDTH));
  localparam logic [CIDX_W-1:0] LAST_IDX   = CIDX_W'(NCHUNK - 1);

  lzd_state_e         state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [SW1-1:0]     shift_q;
  logic               b_gt_a_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [PW-1:0]      diff_q;
  logic [CIDX_W-1:0]  chunk_q;

  logic [W-1:0]       mag_d;
  logic               enc_nz;
  logic [LZW-1:0]     enc_lz;
  logic [SW1-1:0]     shift_hit_d;

`ifdef LZD_SEQ_NORM_EN
  logic [W-1:0]       norm_q;
  logic [W-1:0]       norm_d;
`endif

  // diff_q is shifted left by CHUNK on every empty chunk, so the chunk under test
  // is always its top slice; this equals padded[PW-1-c*CHUNK -: CHUNK].
  lzd_chunk_enc #(
    .CHUNK (CHUNK)
  ) u_enc (
    .chunk_i   (diff_q[PW-1 -: CHUNK]),
    .nonzero_o (enc_nz),
    .lz_o      (enc_lz)
  );

  always_comb begin
    mag_d       = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
    shift_hit_d = SW1'(chunk_q) * SW1'(CHUNK) + SW1'(enc_lz);
  end

`ifdef LZD_SEQ_NORM_EN
  // Already shifted by c*CHUNK; the final lz plus dropping the pad gives diff << shift.
  always_comb begin
    norm_d = W'((diff_q << enc_lz) >> PAD);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      shift_q     <= '0;
      b_gt_a_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      chunk_q     <= '0;
`ifdef LZD_SEQ_NORM_EN
      norm_q      <= '0;
`endif
    end else if (flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            in_ready_q <= 1'b0;
            state_q    <= SUB;
          end
        end
        SUB: begin
          diff_q   <= PW'(mag_d) << PAD;
          b_gt_a_q <= (b_q > a_q);
          chunk_q  <= '0;
          state_q  <= SCAN;
        end
        SCAN: begin
          if (enc_nz) begin
            shift_q     <= shift_hit_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef LZD_SEQ_NORM_EN
            norm_q      <= norm_d;
`endif
          end else if (chunk_q == LAST_IDX) begin
            shift_q     <= ZERO_SHIFT;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef LZD_SEQ_NORM_EN
            norm_q      <= '0;
`endif
          end else begin
            chunk_q <= chunk_q + 1'b1;
            diff_q  <= diff_q << CHUNK;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign shift_amt = shift_q;
  assign b_gt_a    = b_gt_a_q;
`ifdef LZD_SEQ_NORM_EN
  assign norm_mant = norm_q;
`endif

endmodule

// File: tb/tb_lzd_scan_sequencer.sv
// Self-checking bench for lzd_scan_sequencer: directed cases, flush/reset aborts, random pairs.
module tb_lzd_scan_sequencer;

  localparam int M      = 23;
  localparam int EB     = 7;
  localparam int SB     = 1;
  localparam int CHUNK  = 4;
  localparam int W      = M + EB - SB;
  localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
  localparam int SW     = $clog2(W - 1);
  localparam int SW1    = SW + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           flush = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [SW:0]    shift_amt;
  logic           b_gt_a;
`ifdef LZD_SEQ_NORM_EN
  logic [W-1:0]   norm_mant;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  lzd_scan_sequencer #(
    .M          (M),
    .EXTRA_BITS (EB),
    .SIGN_BIT   (SB),
    .CHUNK      (CHUNK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .shift_amt (shift_amt),
    .b_gt_a    (b_gt_a)
`ifdef LZD_SEQ_NORM_EN
    ,
    .norm_mant (norm_mant)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: count leading zeros of the magnitude directly, one bit at a time.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [SW:0] sh, output int lat,
                                output logic [W-1:0] nm, output logic gt);
    logic [W-1:0] d;
    int lz;
    gt = (bv > av);
    d  = (av >= bv) ? av - bv : bv - av;
    if (d == '0) begin
      sh  = SW1'(1 << SW);
      lat = 2 + NCHUNK;
      nm  = '0;
    end else begin
      lz = 0;
      for (int i = W - 1; i >= 0; i--) begin
        if (d[i]) break;
        lz++;
      end
      sh  = SW1'(lz);
      lat = 3 + lz / CHUNK;
      nm  = d << lz;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int hold, input bit noise);
    logic [SW:0]  esh;
    int           elat;
    logic [W-1:0] enm;
    logic         egt;
    int           n;
    model(av, bv, esh, elat, enm, egt);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_idle", in_ready, 1);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (noise) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
    end
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    check("latency", n + 1, elat);
    check("shift_amt", shift_amt, esh);
    check("b_gt_a", b_gt_a, egt);
`ifdef LZD_SEQ_NORM_EN
    check("norm_mant", norm_mant, enm);
`endif
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_shift", shift_amt, esh);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_accept_valid", out_valid, 0);
    check("post_accept_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_shift", shift_amt, 0);
    check("rst_b_gt_a", b_gt_a, 0);
`ifdef LZD_SEQ_NORM_EN
    check("rst_norm", norm_mant, 0);
`endif

    run_op(29'h1000_0000, 29'h0, 0, 1'b0);
    run_op(29'd5, 29'd9, 0, 1'b1);
    run_op(29'h0AB_CDEF, 29'h0AB_CDEF, 0, 1'b0);
    run_op(29'd1, 29'd0, 5, 1'b1);

    // Flush at T+4 while scanning a=1,b=0.
    a = 29'd1; b = 29'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("pre_flush_valid", out_valid, 0);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("flush_quiet", out_valid, 0);
    end
    run_op(29'd2, 29'd0, 0, 1'b0);

    // Flush coinciding with an offered pair in IDLE discards the pair.
    a = 29'd7; b = 29'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_in_ready", in_ready, 1);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("flush_idle_quiet", out_valid, 0);
    end

    // Reset in SCAN with B > A so b_gt_a was already set.
    a = 29'd0; b = 29'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_shift", shift_amt, 0);
    check("midrst_b_gt_a", b_gt_a, 0);
`ifdef LZD_SEQ_NORM_EN
    check("midrst_norm", norm_mant, 0);
`endif
    run_op(29'h0000_0300, 29'h0000_0100, 0, 1'b0);
    run_op(29'h0123_4567, 29'h1FFF_FFFF, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      ra = W'($urandom);
      unique case (r % 4)
        0: rb = W'($urandom);
        1: rb = ra ^ W'($urandom_range(0, 255));
        2: rb = ra;
        default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      endcase
      run_op(ra, rb, r % 3, r[0]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
